// File: rtl/pc_pkg.sv
// +--------------------------------------------------------------------------+
// | pc_pkg: shared state encoding and default addresses for pc_sequencer.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package pc_pkg;

    typedef enum logic [1:0] {
        RESET  = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        TRAP   = 2'd3
    } pc_state_t;

    localparam int unsigned INC_DEFAULT      = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC_DEFAULT = 32'h0000_0100;

endpackage

`default_nettype wire

// File: rtl/adder.sv
// +--------------------------------------------------------------------------+
// | adder: plain WIDTH-bit modulo adder, carry out discarded.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// +--------------------------------------------------------------------------+
// | pc_sequencer: program-counter stage with fetch handshake, halt/resume    |
// | and misaligned-target trap redirection.                                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT),
    parameter logic [WIDTH-1:0] TRAP_VEC = WIDTH'(TRAP_VEC_DEFAULT),
    parameter int unsigned      INC      = INC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             imem_ready,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus_inc,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             halt,
    input  logic             resume,
    output logic             misalign,
    output logic [WIDTH-1:0] trap_pc,
    output logic [1:0]       state
);

    localparam logic [WIDTH-1:0] C_INC = WIDTH'(INC);

    pc_state_t        r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_trap_pc;
    logic [WIDTH-1:0] w_seq;
    logic [WIDTH-1:0] w_nxt;
    logic             w_advance;

    adder #(.WIDTH(WIDTH)) u_adder (
        .a   (r_pc),
        .b   (C_INC),
        .sum (w_seq)
    );

    // Jump outranks branch; the sequential path is the fallback.
    always_comb begin
        w_nxt = w_seq;
        if (jump)
            w_nxt = jump_target;
        else if (branch_taken)
            w_nxt = branch_target;
    end

    assign w_advance = imem_ready & ~stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= RESET;
            r_pc      <= RESET_PC;
            r_trap_pc <= '0;
        end else begin
            case (r_state)
                RESET: r_state <= RUN;
                RUN: begin
                    if (halt) begin
                        r_state <= HALTED;
                    end else if (w_advance) begin
                        if (w_nxt[1:0] != 2'b00) begin
                            r_state   <= TRAP;
                            r_pc      <= TRAP_VEC;
                            r_trap_pc <= w_nxt;
                        end else begin
                            r_pc <= w_nxt;
                        end
                    end
                end
                HALTED: begin
                    if (resume && !halt)
                        r_state <= RUN;
                end
                TRAP:    r_state <= RUN;
                default: r_state <= RESET;
            endcase
        end
    end

    assign pc          = r_pc;
    assign pc_plus_inc = w_seq;
    assign trap_pc     = r_trap_pc;
    assign state       = r_state;
    assign fetch_valid = (r_state == RUN);
    assign misalign    = (r_state == TRAP);

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// +--------------------------------------------------------------------------+
// | tb_pc_sequencer: directed self-checking bench for pc_sequencer.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        imem_ready;
    logic        fetch_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus_inc;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        halt;
    logic        resume;
    logic        misalign;
    logic [31:0] trap_pc;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .imem_ready    (imem_ready),
        .fetch_valid   (fetch_valid),
        .pc            (pc),
        .pc_plus_inc   (pc_plus_inc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .halt          (halt),
        .resume        (resume),
        .misalign      (misalign),
        .trap_pc       (trap_pc),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; imem_ready = 1'b1;
        branch_taken = 1'b0; branch_target = '0;
        jump = 1'b0; jump_target = '0;
        halt = 1'b0; resume = 1'b0;

        #2;
        check("rst_state",  {30'd0, state}, 32'd0);
        check("rst_pc",     pc, 32'h0);
        check("rst_trappc", trap_pc, 32'h0);
        check("rst_fv",     {31'd0, fetch_valid}, 32'd0);
        check("rst_mis",    {31'd0, misalign}, 32'd0);
        check("rst_plus",   pc_plus_inc, 32'h4);

        tick();
        rst = 1'b1;
        tick();
        check("run_state", {30'd0, state}, 32'd1);
        check("run_pc0",   pc, 32'h0);
        check("run_fv",    {31'd0, fetch_valid}, 32'd1);
        tick(); check("seq_pc4", pc, 32'h4);
        tick(); check("seq_pc8", pc, 32'h8);

        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait_pc", pc, 32'h8);
            check("wait_fv", {31'd0, fetch_valid}, 32'd1);
        end
        imem_ready = 1'b1;
        tick(); check("ready_pc12", pc, 32'hC);

        jump = 1'b1; jump_target = 32'h40;
        branch_taken = 1'b1; branch_target = 32'h80;
        tick(); check("jump_wins", pc, 32'h40);
        stall = 1'b1;
        tick(); check("stall_hold", pc, 32'h40);
        stall = 1'b0; jump = 1'b0;
        tick(); check("branch_pc", pc, 32'h80);

        branch_target = 32'h42;
        tick();
        check("trap_state", {30'd0, state}, 32'd3);
        check("trap_mis",   {31'd0, misalign}, 32'd1);
        check("trap_fv",    {31'd0, fetch_valid}, 32'd0);
        check("trap_pcval", trap_pc, 32'h42);
        check("trap_vec",   pc, 32'h100);
        branch_taken = 1'b0;
        tick();
        check("post_trap_state", {30'd0, state}, 32'd1);
        check("post_trap_mis",   {31'd0, misalign}, 32'd0);
        check("post_trap_pc",    pc, 32'h100);
        tick(); check("post_trap_seq", pc, 32'h104);

        jump = 1'b1; jump_target = 32'h20;
        tick(); check("jump_20", pc, 32'h20);
        jump = 1'b0; halt = 1'b1;
        tick();
        check("halt_state", {30'd0, state}, 32'd2);
        check("halt_fv",    {31'd0, fetch_valid}, 32'd0);
        check("halt_pc",    pc, 32'h20);
        resume = 1'b1;
        tick(); check("halt_resume_both", {30'd0, state}, 32'd2);
        halt = 1'b0; resume = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("halted_pc", pc, 32'h20);
        end
        resume = 1'b1;
        tick();
        check("resume_state", {30'd0, state}, 32'd1);
        check("resume_pc",    pc, 32'h20);
        resume = 1'b0;
        tick(); check("resume_adv", pc, 32'h24);

        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        tick();
        check("top_pc",   pc, 32'hFFFF_FFFC);
        check("top_plus", pc_plus_inc, 32'h0);
        jump = 1'b0;
        tick(); check("wrap_pc", pc, 32'h0);
        tick(); check("wrap_pc4", pc, 32'h4);

        #2 rst = 1'b0;
        #1;
        check("async_pc",    pc, 32'h0);
        check("async_state", {30'd0, state}, 32'd0);
        check("async_fv",    {31'd0, fetch_valid}, 32'd0);
        check("async_trap",  trap_pc, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        check("rerun_state", {30'd0, state}, 32'd1);
        tick(); check("rerun_pc", pc, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
